// File: rtl/s2_pkg.sv
// rtl/s2_pkg.sv - shared states and frame geometry for the S2 plane relay
// Purpose: FSM state type plus RX/TX frame constants used by the relay and its serializer.
// Ports: none (package).
package s2_pkg;

  typedef enum logic [1:0] {
    ST_RX,
    ST_WAIT,
    ST_TX,
    ST_DONE
  } s2_state_e;

  localparam int RX_FRAME = 22;  // 3 index bits + 18 data bits + 1 gap
  localparam int TX_FRAME = 14;  // 13 frame bits + 1 gap
  localparam int N_PLANES = 8;
  localparam int N_WORDS  = 18;
  localparam int IDX_W    = 3;   // width of the per-plane index field
  localparam int FRAME_W  = 13;  // {address[4:0], data[7:0]}

endpackage

// File: rtl/s2_tx_serializer.sv
// rtl/s2_tx_serializer.sv - TX frame shift register with 0..13 cycle counter
// Purpose: holds one {address, data} frame and shifts it out MSB first, then spends one gap cycle.
// Ports:
//   clk, rst      : clock, async active-low reset
//   i_en          : relay is in its TX state
//   i_hold        : freeze shift register and counter (link direction turned away)
//   i_load        : load i_word and restart at cycle 0 (overrides hold/en)
//   i_word        : next frame {address, data}
//   o_bit         : current frame bit (MSB of shift register)
//   o_last_bit    : counter is on the last frame bit (c = 12)
//   o_gap         : counter is on the gap cycle (c = 13)
module s2_tx_serializer
  import s2_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_hold,
  input  logic         i_load,
  input  logic [W-1:0] i_word,
  output logic         o_bit,
  output logic         o_last_bit,
  output logic         o_gap
);

  localparam int CW = $clog2(TX_FRAME);
  localparam logic [CW-1:0] C_GAP      = CW'(TX_FRAME - 1);
  localparam logic [CW-1:0] C_LAST_BIT = CW'(TX_FRAME - 2);

  logic [W-1:0]  r_sh;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_word;
      r_cnt <= '0;
    end else if (i_en && !i_hold) begin
      if (r_cnt == C_GAP) begin
        r_cnt <= '0;
      end else begin
        r_sh  <= {r_sh[W-2:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_bit      = r_sh[W-1];
  assign o_last_bit = (r_cnt == C_LAST_BIT);
  assign o_gap      = (r_cnt == C_GAP);

endmodule

// File: rtl/s2_plane_relay.sv
// rtl/s2_plane_relay.sv - S2 host: rebuilds RB2 from S1 bit planes, then streams RB2 back as frames
// Purpose: RX samples 8 bit-plane frames from sd and read-modify-writes one bit per word into RB2;
//          after the last plane it waits for updown, then serializes RB2 as {address, data} frames.
// Ports:
//   clk, rst  : clock, async active-low reset
//   updown    : link direction, 1 = this block may drive sd (honoured only in TX)
//   sen       : shared enable wire, never driven here
//   sd        : shared serial data wire
//   S2_done   : high once the last TX frame's gap cycle has completed
//   RB2_RW    : 1 = read, 0 = write on the closing posedge
//   RB2_A     : registered RB2 address
//   RB2_D     : RB2_Q with bit k replaced by the held sample bit
//   RB2_Q     : asynchronous read data mem[RB2_A]
module s2_plane_relay #(
  parameter int N_WORDS = 18,
  parameter int AW      = 5,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          updown,
  inout  wire           sen,
  inout  wire           sd,
  output logic          S2_done,
  output logic          RB2_RW,
  output logic [AW-1:0] RB2_A,
  output logic [DW-1:0] RB2_D,
  input  logic [DW-1:0] RB2_Q
);

  import s2_pkg::*;

  localparam int RCW = $clog2(RX_FRAME);
  localparam int PW  = $clog2(N_PLANES);

  localparam logic [RCW-1:0] C_RX_IDX_END = RCW'(IDX_W);
  localparam logic [RCW-1:0] C_RX_GAP     = RCW'(RX_FRAME - 1);
  localparam logic [PW-1:0]  C_LAST_PLANE = PW'(N_PLANES - 1);
  localparam logic [AW-1:0]  C_LAST_ADDR  = AW'(N_WORDS - 1);
  // Data bits arrive for the highest address first: c = IDX_W carries N_WORDS-1.
  localparam logic [AW-1:0]  C_RX_ADDR_BASE = AW'(N_WORDS - 1 + IDX_W);

  s2_state_e      r_state;
  logic [RCW-1:0] r_rx_cnt;
  logic [PW-1:0]  r_plane;
  logic [IDX_W-1:0] r_idx;
  logic           r_bit;
  logic           r_rw;
  logic [AW-1:0]  r_addr;
  logic           r_done;
  logic           r_tx_last;

  logic           w_tx_en;
  logic           w_load;
  logic           w_tx_bit;
  logic           w_last_bit;
  logic           w_gap;
  logic [IDX_W-1:0] w_k;
  logic [DW-1:0]  w_d;
  logic           w_sen_unused;

  assign w_sen_unused = sen;

  // The index field carries the complement of the bit position.
  assign w_k = ~r_idx;

  always_comb begin
    w_d      = RB2_Q;
    w_d[w_k] = r_bit;
  end

  assign w_tx_en = (r_state == ST_TX);
  // First frame loads in WAIT (RB2_A is 0 there); later frames load at the end of each
  // gap, when RB2_A already points at the next word.
  assign w_load  = updown && ((r_state == ST_WAIT) ||
                              ((r_state == ST_TX) && w_gap && !r_tx_last));

  s2_tx_serializer #(
    .W (AW + DW)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_tx_en),
    .i_hold     (!updown),
    .i_load     (w_load),
    .i_word     ({RB2_A, RB2_Q}),
    .o_bit      (w_tx_bit),
    .o_last_bit (w_last_bit),
    .o_gap      (w_gap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RX;
      r_rx_cnt  <= '0;
      r_plane   <= '0;
      r_idx     <= '0;
      r_bit     <= 1'b0;
      r_rw      <= 1'b1;
      r_addr    <= '0;
      r_done    <= 1'b0;
      r_tx_last <= 1'b0;
    end else begin
      r_rw <= 1'b1;
      case (r_state)
        ST_RX: begin
          if (r_rx_cnt < C_RX_IDX_END) begin
            r_idx <= {r_idx[IDX_W-2:0], sd};
          end else if (r_rx_cnt != C_RX_GAP) begin
            // Sample now, write during the following cycle.
            r_bit  <= sd;
            r_addr <= C_RX_ADDR_BASE - AW'(r_rx_cnt);
            r_rw   <= 1'b0;
          end
          if (r_rx_cnt == C_RX_GAP) begin
            r_rx_cnt <= '0;
            if (r_plane == C_LAST_PLANE) begin
              r_state <= ST_WAIT;
              r_addr  <= '0;
            end else begin
              r_plane <= r_plane + 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end

        ST_WAIT: begin
          r_addr <= '0;
          if (updown) begin
            r_state <= ST_TX;
          end
        end

        ST_TX: begin
          if (updown) begin
            if (w_last_bit) begin
              // Present the next word during the gap so it can be loaded at its end.
              if (r_addr == C_LAST_ADDR) begin
                r_tx_last <= 1'b1;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end else if (w_gap && r_tx_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          r_done <= 1'b1;
        end

        default: begin
          r_state <= ST_RX;
        end
      endcase
    end
  end

  assign sd      = (w_tx_en && updown) ? (w_gap ? 1'b0 : w_tx_bit) : 1'bz;
  assign S2_done = r_done;
  assign RB2_RW  = r_rw;
  assign RB2_A   = r_addr;
  assign RB2_D   = w_d;

endmodule

// File: doc/s2_plane_relay.md
# s2_plane_relay

Second serial host of the two-host link. It receives the bit-plane serial stream from the S1 host and rebuilds each word in RB2 with a read-modify-write per bit. When `updown` goes high it serializes RB2 back to S1 as address/data frames. It sits directly downstream of S1 on the shared `sd` wire and then upstream of S1's receive phase.

## Interface
- `N_WORDS`, 18, number of words in RB2.
- `AW`, 5, RB2 address width.
- `DW`, 8, RB2 data width.
- `clk` in 1: single clock. All logic uses the posedge.
- `rst` in 1: asynchronous, active-low reset.
- `updown` in 1: link direction. 0 = S1 drives `sd` and this block receives. 1 = this block drives `sd`.
- `sen` inout 1: never driven by this block (always z). Ignored.
- `sd` inout 1: serial data.
  - Driven only when `updown`==1 and state is TX.
  - High-impedance otherwise.
- `S2_done` out 1: high once the last TX frame's gap cycle completes.
- `RB2_RW` out 1: 1 = read, 0 = write. Written on the posedge while 0.
- `RB2_A` out AW: RB2 address. Registered.
- `RB2_D` out DW: write data. Combinational: `RB2_Q` with bit `k` replaced by the held sample bit.
- `RB2_Q` in DW: asynchronous-read data, `mem[RB2_A]`.

## Operation
- States: RX, WAIT, TX, DONE. Reset enters RX.
- RX frame format: 22 cycles per frame, 8 frames.
  - c=0..2: index field, MSB first. The field carries ~k, so k = ~field. The first frame carries field 000, meaning bit 7.
  - c=3..20: data bits for addresses 17 down to 0.
  - c=21: gap cycle. Not sampled.
- RX sampling and write:
  - At each data-bit posedge, latch sd into `bit_q` and latch the address.
  - Next cycle: `RB2_A`=address, `RB2_RW`=0, `RB2_D`=Q with bit k := `bit_q`. The write happens at that cycle's closing posedge.
  - Outside write cycles, `RB2_RW`=1.
- Every bit of every word is rewritten, so RB2 needs no prior initialisation.
- After the posedge ending frame 7's gap, go to WAIT.
  - In WAIT: `RB2_A`=0, `RB2_RW`=1.
  - `updown` is ignored in RX.
- TX frame format: 14 cycles per frame, addresses 0..17 ascending.
  - Shift register `sh[12:0]` = {address[4:0], data[7:0]}.
  - c=0..12: `sd`=`sh[12-c]`.
  - c=13: gap cycle. `sd`=0 and `RB2_A`=next address. At the closing posedge, `sh` loads {next address, Q}.
- Entering TX: at the first posedge in WAIT with `updown`==1, load `sh`={0, Q} and set c=0.
- `updown`==0 during TX: `sd` is released and all TX counters hold. TX resumes when `updown` returns to 1.
- After address 17's gap cycle, go to DONE: `S2_done`=1, `sd`=z. DONE holds until reset.
- Reset values: `S2_done`=0, `RB2_RW`=1, `RB2_A`=0, `sd`=z, all counters 0.
- Reset mid-operation aborts everything and restarts RX. Partial RB2 writes are not undone.

## Timing
- S1 drives `sd` on negedges; this block samples on posedges, a half-cycle margin.
- `rst` must deassert while `clk` is high. The following negedge carries frame-0 bit 0, which is sampled at the next posedge.
- RX write latency: one cycle after sampling. The last write lands at the posedge ending frame 7's gap.
- Full RX pass: 176 cycles from the first sample to WAIT.
- TX bits change on posedges; S1 samples them on the following negedge.
- Full TX pass: 252 cycles of `updown`==1. `S2_done` rises on the posedge ending cycle 252.
- Host responsibility: align the `updown` rise so that S1's first receive negedge falls inside TX c=0.

## Structure
- Package `s2_pkg` holds:
  - state enum;
  - `RX_FRAME`=22, `TX_FRAME`=14, `N_PLANES`=8, `N_WORDS`=18;
  - index-field width 3 and frame width 13.
- One sub-module, `s2_tx_serializer`: the 13-bit load/shift register plus the 0..13 cycle counter, with a hold input driven from `updown`.

## Test plan
- Full RX: S1 model sends RB1[a]=8'h40+a -> after 176 cycles RB2[a]==8'h40+a for a=0..17; state WAIT; `sd`=z.
- Single plane: only frame 0 (field 000, all ones) -> bit 7 of all 18 words is 1; bits 6..0 unchanged; `RB2_RW`=0 for exactly 18 cycles.
- TX: RB2[a]=a^8'hA5, `updown`=1 -> 18 frames of {a[4:0], data} MSB first, each followed by a 0 gap bit; `S2_done` high at cycle 252.
- Direction guard: `updown`=1 pulses during RX -> `sd` stays z; RX result identical to the first scenario.
- TX pause: `updown` low for 5 cycles mid-frame 3 -> `sd`=z during the pause; the bit sequence resumes exactly where it stopped; `S2_done` delayed by 5 cycles.
- Reset mid-TX at frame 9 -> next cycle all outputs at reset values; a new RX pass then completes correctly.
